sdram_probe_clear: RTL
======================

// Module: sdram_probe_clear
// PURPOSE
//  Power-on SDRAM presence/size probe plus background zero-fill engine for the menu core.
//  Sits between the sdram controller (command side) and hps_io (status_menumask).
//  Probes aliasing at 0/16M/32M/64M word addresses and reports a cfg word to the HPS.
//  Then zero-fills SDRAM continuously so the next core starts on clean RAM.
// PARAMETERS
//  ADDR_W    27     width of ram_addr (word address; bit 26 = 64M boundary)
//  CLR_W     25     clear counter width; clear region = 0 .. 2^CLR_W-1
//  CLR_GAP   32     min clk_sys cycles between clear writes (leaves bus for refresh)
//  TIMEOUT   4096   max cycles waiting for ram_ready in any probe state
// PORTS
//  clk_sys    in   1       system clock
//  RESET      in   1       synchronous, active-high reset
//  ram_ready  in   1       controller idle/ready; drops the cycle after a command
//  ram_dout   in   16      read data, valid when ram_ready returns after a read
//  ram_addr   out  ADDR_W  command address
//  ram_din    out  16      write data
//  ram_we     out  1       write command, 1-cycle pulse
//  ram_rd     out  1       read command, 1-cycle pulse
//  cfg        out  16      [0] base ok, [1] 32M ok, [2] 64M ok, [13] timeout, [14] first clear pass done, [15] probe done
//  clr_active out  1       high while clear engine owns the bus
// BEHAVIOUR
//  Reset: all outputs 0, cfg=0, FSM->WAIT_INIT, clear counter=0, gap counter=0. RESET mid-op aborts immediately; no pulse in reset cycle.
//  Commands: ram_we/ram_rd never both high; issued only when ram_ready=1 in the issuing state;
//   each command is followed by one unconditional WAIT cycle (ready not yet dropped) before ready is sampled.
//  ram_addr/ram_din registered together with the pulse and held until the next command.
//  FSM (each Wx = issue, then WAIT, then poll ready):
//   WAIT_INIT: ready=1 -> W64. W64: write 3128 @ 0x4000000. W32: write 2064 @ 0x2000000.
//   W0: write 1032 @ 0x0000000. W16: write 12345 @ 0x1000000 (bus scrub).
//   R64: read @ 0x4000000; on ready cfg[2]<=(dout==3128). R32 -> cfg[1]<=(dout==2064).
//   R0 -> cfg[0]<=(dout==1032); cfg[15]<=1; -> CLEAR.
//  Read data is sampled on the first cycle ready=1 after the post-read WAIT.
//  Timeout: counter resets on every state change; reaching TIMEOUT in any poll -> cfg[13]<=1,
//   that probe bit stays 0, cfg[15]<=1, go to CLEAR. Timeout never fires in CLEAR.
//  CLEAR: when gap counter == CLR_GAP-1 and ready=1: ram_we=1, ram_din=0, ram_addr=zero-extended clear counter;
//   counter +1, gap counter ->0. Otherwise gap counter saturates at CLR_GAP-1.
//  Clear counter wraps 2^CLR_W-1 -> 0; on that wrap cfg[14]<=1 (sticky). Clearing never stops.
//  clr_active = (state==CLEAR). cfg[15:13] sticky until RESET; cfg[12:3]=0 always.
//  Aliasing semantics: 32M-only part aliases 0x4000000 onto 0, so R64 reads 1032 -> cfg[2]=0.
// TESTING
//  1. 128MB model (no aliasing, ready 2-cycle busy) -> cfg=0x8007 after probe; first clear write addr 0, din 0.
//  2. 32MB model (addr bit 25/26 ignored) -> cfg=0x8001; 64MB model (bit 26 ignored) -> cfg=0x8003.
//  3. ready stuck 0 after W64 -> after TIMEOUT cycles cfg=0xA000, clr_active=1.
//  4. CLR_W=4, CLR_GAP=4, ready always 1 -> writes every 4 cycles to 0..15, cfg[14] sets on wrap to 0, continues.
//  5. RESET asserted during R32 and during CLEAR -> next cycle outputs 0, cfg=0, probe restarts at W64.
//  6. Protocol checker: no we&rd, no command within 1 cycle of previous, none while ready=0.

Source files
------------

// File: rtl/sdram_probe_clear.sv
`default_nettype none
// ============================================================================
// Module   : sdram_probe_clear
// Brief    : Power-on SDRAM size probe (0/16M/32M/64M aliasing) followed by a
//            perpetual, rate-limited background zero-fill of the SDRAM.
// Revision : 1.0  initial release
// ============================================================================
module sdram_probe_clear #(
    parameter int ADDR_W  = 27,
    parameter int CLR_W   = 25,
    parameter int CLR_GAP = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              ram_ready,
    input  logic [15:0]       ram_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_din,
    output logic              ram_we,
    output logic              ram_rd,
    output logic [15:0]       cfg,
    output logic              clr_active
);

    localparam int c_TMO_W = $clog2(TIMEOUT) + 1;
    localparam int c_GAP_W = $clog2(CLR_GAP) + 1;

    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(CLR_GAP - 1);

    localparam logic [ADDR_W-1:0] c_ADDR_64M = ADDR_W'(32'h0400_0000);
    localparam logic [ADDR_W-1:0] c_ADDR_32M = ADDR_W'(32'h0200_0000);
    localparam logic [ADDR_W-1:0] c_ADDR_16M = ADDR_W'(32'h0100_0000);
    localparam logic [ADDR_W-1:0] c_ADDR_0   = '0;

    localparam logic [15:0] c_PAT_64M   = 16'd3128;
    localparam logic [15:0] c_PAT_32M   = 16'd2064;
    localparam logic [15:0] c_PAT_0     = 16'd1032;
    localparam logic [15:0] c_PAT_SCRUB = 16'd12345;

    // Each issue state doubles as the ready-poll (and read capture) of the
    // command before it; ST_WAIT holds the return state for one cycle.
    typedef enum logic [3:0] {
        ST_WAIT_INIT = 4'd0,
        ST_W64       = 4'd1,
        ST_W32       = 4'd2,
        ST_W0        = 4'd3,
        ST_W16       = 4'd4,
        ST_R64       = 4'd5,
        ST_R32       = 4'd6,
        ST_R0        = 4'd7,
        ST_FIN       = 4'd8,
        ST_WAIT      = 4'd9,
        ST_CLEAR     = 4'd10
    } state_t;

    state_t              r_state;
    state_t              r_ret;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [c_GAP_W-1:0]  r_gap;
    logic [CLR_W-1:0]    r_clr;
    logic [2:0]          r_ok;
    logic                r_tmo_flag;
    logic                r_pass;
    logic                r_done;

    state_t              w_next;
    state_t              w_ret;
    logic                w_we;
    logic                w_rd;
    logic [ADDR_W-1:0]   w_addr;
    logic [15:0]         w_din;
    logic                w_cap_64m;
    logic                w_cap_32m;
    logic                w_cap_0;
    logic                w_clr_fire;
    logic                w_poll;
    logic                w_tmo_hit;

    assign w_poll    = (r_state != ST_WAIT) && (r_state != ST_CLEAR);
    assign w_tmo_hit = w_poll && !ram_ready && (r_tmo == c_TMO_LAST);

    always_comb begin
        w_next     = r_state;
        w_ret      = r_ret;
        w_we       = 1'b0;
        w_rd       = 1'b0;
        w_addr     = ram_addr;
        w_din      = ram_din;
        w_cap_64m  = 1'b0;
        w_cap_32m  = 1'b0;
        w_cap_0    = 1'b0;
        w_clr_fire = 1'b0;

        case (r_state)
            ST_WAIT_INIT: begin
                if (ram_ready) w_next = ST_W64;
            end
            ST_W64: begin
                if (ram_ready) begin
                    w_we = 1'b1; w_addr = c_ADDR_64M; w_din = c_PAT_64M;
                    w_next = ST_WAIT; w_ret = ST_W32;
                end
            end
            ST_W32: begin
                if (ram_ready) begin
                    w_we = 1'b1; w_addr = c_ADDR_32M; w_din = c_PAT_32M;
                    w_next = ST_WAIT; w_ret = ST_W0;
                end
            end
            ST_W0: begin
                if (ram_ready) begin
                    w_we = 1'b1; w_addr = c_ADDR_0; w_din = c_PAT_0;
                    w_next = ST_WAIT; w_ret = ST_W16;
                end
            end
            ST_W16: begin
                // Drives a different value onto the bus so a floating data
                // bus cannot echo the last written pattern back on reads.
                if (ram_ready) begin
                    w_we = 1'b1; w_addr = c_ADDR_16M; w_din = c_PAT_SCRUB;
                    w_next = ST_WAIT; w_ret = ST_R64;
                end
            end
            ST_R64: begin
                if (ram_ready) begin
                    w_rd = 1'b1; w_addr = c_ADDR_64M;
                    w_next = ST_WAIT; w_ret = ST_R32;
                end
            end
            ST_R32: begin
                if (ram_ready) begin
                    w_cap_64m = 1'b1;
                    w_rd = 1'b1; w_addr = c_ADDR_32M;
                    w_next = ST_WAIT; w_ret = ST_R0;
                end
            end
            ST_R0: begin
                if (ram_ready) begin
                    w_cap_32m = 1'b1;
                    w_rd = 1'b1; w_addr = c_ADDR_0;
                    w_next = ST_WAIT; w_ret = ST_FIN;
                end
            end
            ST_FIN: begin
                if (ram_ready) begin
                    w_cap_0 = 1'b1;
                    w_next  = ST_CLEAR;
                end
            end
            ST_WAIT: begin
                w_next = r_ret;
            end
            ST_CLEAR: begin
                if ((r_gap == c_GAP_LAST) && ram_ready) begin
                    w_we = 1'b1; w_addr = ADDR_W'(r_clr); w_din = 16'h0000;
                    w_clr_fire = 1'b1;
                end
            end
            default: begin
                w_next = ST_WAIT_INIT;
            end
        endcase

        if (w_tmo_hit) begin
            w_next = ST_CLEAR;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_state  <= ST_WAIT_INIT;
            r_ret    <= ST_WAIT_INIT;
            ram_we   <= 1'b0;
            ram_rd   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            r_state  <= w_next;
            r_ret    <= w_ret;
            ram_we   <= w_we;
            ram_rd   <= w_rd;
            ram_addr <= w_addr;
            ram_din  <= w_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_tmo      <= '0;
            r_gap      <= '0;
            r_clr      <= '0;
            r_ok       <= '0;
            r_tmo_flag <= 1'b0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (w_poll && (r_tmo != c_TMO_LAST)) begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end

            if (w_cap_64m) r_ok[2] <= (ram_dout == c_PAT_64M);
            if (w_cap_32m) r_ok[1] <= (ram_dout == c_PAT_32M);
            if (w_cap_0) begin
                r_ok[0] <= (ram_dout == c_PAT_0);
                r_done  <= 1'b1;
            end
            if (w_tmo_hit) begin
                r_tmo_flag <= 1'b1;
                r_done     <= 1'b1;
            end

            if (r_state == ST_CLEAR) begin
                if (w_clr_fire) begin
                    r_gap <= '0;
                end else if (r_gap != c_GAP_LAST) begin
                    r_gap <= r_gap + c_GAP_W'(1);
                end
            end

            if (w_clr_fire) begin
                r_clr <= r_clr + CLR_W'(1);
                if (r_clr == {CLR_W{1'b1}}) r_pass <= 1'b1;
            end
        end
    end

    assign cfg        = {r_done, r_pass, r_tmo_flag, 10'b0, r_ok};
    assign clr_active = (r_state == ST_CLEAR);

endmodule
`default_nettype wire
